// File: rtl/ifm_pingpong_writer_pkg.sv
// ---------------------------------------------------------------------------
// ifm_pingpong_writer_pkg
//   Shared definitions for the ping-pong IFM write-side controller:
//   - consumer FSM state encoding (2 bits)
//   - helpers deriving the pixel-address and map-select widths
// ---------------------------------------------------------------------------
package ifm_pingpong_writer_pkg;

   typedef enum logic [1:0] {
      C_IDLE   = 2'd0,   // no frame handed to the consumer
      C_LAUNCH = 2'd1,   // start pulse issued, waiting for consumer to leave idle
      C_BUSY   = 2'd2    // consumer reading rd_bank_sel
   } cons_state_e;

   // Pixel address width for a square map of side 'side'.
   function automatic int ifm_addr_w(input int side);
      return (side * side > 1) ? $clog2(side * side) : 1;
   endfunction

   // Map select width; at least one bit even for a single map.
   function automatic int ifm_map_w(input int n_maps);
      return (n_maps > 1) ? $clog2(n_maps) : 1;
   endfunction

endpackage

// File: rtl/ifm_write_addr_gen.sv
// ---------------------------------------------------------------------------
// ifm_write_addr_gen
//   Pixel/map counters for the IFM write path.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     accept      : a pixel is being written this cycle
//     addr        : pixel address of the current (accepted) pixel
//     map         : map index of the current pixel
//     frame_done  : accept of the last pixel of the last map (combinational)
// ---------------------------------------------------------------------------
module ifm_write_addr_gen #(
   parameter int IFM_SIZE_NEXT  = 10,
   parameter int NUMBER_OF_MAPS = 2,
   parameter int ADDR_W         = 7,
   parameter int MAP_W          = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              accept,
   output logic [ADDR_W-1:0] addr,
   output logic [MAP_W-1:0]  map,
   output logic              frame_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
   localparam logic [MAP_W-1:0]  LAST_MAP  = MAP_W'(NUMBER_OF_MAPS - 1);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [MAP_W-1:0]  map_q, map_d;
   logic              addr_wrap;

   always_comb begin
      addr_d     = addr_q;
      map_d      = map_q;
      addr_wrap  = (addr_q == LAST_ADDR);
      frame_done = accept & addr_wrap & (map_q == LAST_MAP);
      if (accept) begin
         if (addr_wrap) begin
            addr_d = '0;
            map_d  = (map_q == LAST_MAP) ? '0 : map_q + MAP_W'(1);
         end else begin
            addr_d = addr_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         map_q  <= '0;
      end else begin
         addr_q <= addr_d;
         map_q  <= map_d;
      end
   end

   assign addr = addr_q;
   assign map  = map_q;

endmodule

// File: rtl/ifm_pingpong_writer.sv
// ---------------------------------------------------------------------------
// ifm_pingpong_writer
//   Write-side controller of the ping-pong IFM memory between two layers.
//   Writes producer pixels into the current write bank, marks a bank full
//   when a frame completes, launches the consumer on the oldest full bank
//   and frees that bank when the consumer returns to idle.
//   Ports:
//     clk, reset      : clock, asynchronous active-high reset
//     wr_valid/data   : producer pixel strobe and value
//     ready_to_prev   : current write bank is free
//     mem_*           : registered memory write port (we/bank/map/addr/wdata)
//     end_from_next   : consumer idle level (1 = idle, 0 = reading)
//     start_to_next   : one-cycle consumer launch pulse
//     rd_bank_sel     : bank owned by the consumer
//     overflow        : sticky, pixel arrived while not ready
// ---------------------------------------------------------------------------
module ifm_pingpong_writer
   import ifm_pingpong_writer_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int IFM_SIZE_NEXT  = 10,
   parameter int NUMBER_OF_MAPS = 2,
   parameter int ADDR_W         = ifm_addr_w(IFM_SIZE_NEXT),
   parameter int MAP_W          = ifm_map_w(NUMBER_OF_MAPS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  ready_to_prev,
   output logic                  mem_we,
   output logic                  mem_bank,
   output logic [MAP_W-1:0]      mem_map,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  end_from_next,
   output logic                  start_to_next,
   output logic                  rd_bank_sel,
   output logic                  overflow
);

   cons_state_e           state_q, state_d;
   logic [1:0]            bank_full_q, bank_full_d;
   logic                  wr_bank_q, wr_bank_d;
   logic                  launch_bank_q, launch_bank_d;
   logic                  rd_bank_sel_q, rd_bank_sel_d;
   logic                  start_q, start_d;
   logic                  overflow_q, overflow_d;
   logic                  mem_we_q, mem_we_d;
   logic                  mem_bank_q, mem_bank_d;
   logic [MAP_W-1:0]      mem_map_q, mem_map_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic                  accept, frame_done, release_bank, launch_ok;
   logic [ADDR_W-1:0]     gen_addr;
   logic [MAP_W-1:0]      gen_map;

   assign ready_to_prev = ~bank_full_q[wr_bank_q];
   assign accept        = wr_valid & ready_to_prev;
   // Banks are handed out in fill order, so launch_bank always names the oldest full one.
   assign launch_ok     = bank_full_q[launch_bank_q] & end_from_next;

   ifm_write_addr_gen #(
      .IFM_SIZE_NEXT  (IFM_SIZE_NEXT),
      .NUMBER_OF_MAPS (NUMBER_OF_MAPS),
      .ADDR_W         (ADDR_W),
      .MAP_W          (MAP_W)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .accept     (accept),
      .addr       (gen_addr),
      .map        (gen_map),
      .frame_done (frame_done)
   );

   // Consumer FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         C_IDLE:   if (launch_ok)      state_d = C_LAUNCH;
         // end_from_next is still high right after the pulse; only its fall
         // proves the consumer took the bank.
         C_LAUNCH: if (!end_from_next) state_d = C_BUSY;
         C_BUSY:   if (end_from_next)  state_d = C_IDLE;
         default:                      state_d = C_IDLE;
      endcase
   end

   // Consumer FSM: outputs
   always_comb begin
      start_d       = 1'b0;
      rd_bank_sel_d = rd_bank_sel_q;
      release_bank  = 1'b0;
      case (state_q)
         C_IDLE: begin
            if (launch_ok) begin
               start_d       = 1'b1;
               rd_bank_sel_d = launch_bank_q;
            end
         end
         C_BUSY:  release_bank = end_from_next;
         default: ;
      endcase
   end

   // Bank ownership; frame completion and release may land in the same cycle
   // on different banks, so both updates are applied independently.
   always_comb begin
      bank_full_d   = bank_full_q;
      wr_bank_d     = wr_bank_q;
      launch_bank_d = launch_bank_q;
      if (frame_done) begin
         bank_full_d[wr_bank_q] = 1'b1;
         wr_bank_d              = ~wr_bank_q;
      end
      if (release_bank) begin
         bank_full_d[rd_bank_sel_q] = 1'b0;
         launch_bank_d              = ~launch_bank_q;
      end
   end

   // Write pipeline: address fields hold the last written pixel between writes.
   always_comb begin
      mem_we_d    = accept;
      mem_bank_d  = accept ? wr_bank_q : mem_bank_q;
      mem_map_d   = accept ? gen_map   : mem_map_q;
      mem_addr_d  = accept ? gen_addr  : mem_addr_q;
      mem_wdata_d = accept ? wr_data   : mem_wdata_q;
      overflow_d  = overflow_q | (wr_valid & ~ready_to_prev);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= C_IDLE;
         bank_full_q   <= 2'b00;
         wr_bank_q     <= 1'b0;
         launch_bank_q <= 1'b0;
         rd_bank_sel_q <= 1'b0;
         start_q       <= 1'b0;
         overflow_q    <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_bank_q    <= 1'b0;
         mem_map_q     <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         bank_full_q   <= bank_full_d;
         wr_bank_q     <= wr_bank_d;
         launch_bank_q <= launch_bank_d;
         rd_bank_sel_q <= rd_bank_sel_d;
         start_q       <= start_d;
         overflow_q    <= overflow_d;
         mem_we_q      <= mem_we_d;
         mem_bank_q    <= mem_bank_d;
         mem_map_q     <= mem_map_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   // A bank being completed can never be the one the consumer is releasing.
   a_no_same_bank: assert property (@(posedge clk) disable iff (reset)
      !(frame_done && release_bank && (wr_bank_q == rd_bank_sel_q)));

   assign mem_we        = mem_we_q;
   assign mem_bank      = mem_bank_q;
   assign mem_map       = mem_map_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign start_to_next = start_q;
   assign rd_bank_sel   = rd_bank_sel_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_ifm_pingpong_writer.sv
module tb_ifm_pingpong_writer;

   localparam int DW    = 32;
   localparam int SIDE  = 10;
   localparam int NMAPS = 2;
   localparam int PIX   = SIDE * SIDE;
   localparam int FRAME = PIX * NMAPS;
   localparam int AW    = 7;
   localparam int MW    = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          ready_to_prev;
   logic          mem_we;
   logic          mem_bank;
   logic [MW-1:0] mem_map;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          end_from_next;
   logic          start_to_next;
   logic          rd_bank_sel;
   logic          overflow;

   always #5 clk = ~clk;

   ifm_pingpong_writer #(
      .DATA_WIDTH     (DW),
      .IFM_SIZE_NEXT  (SIDE),
      .NUMBER_OF_MAPS (NMAPS),
      .ADDR_W         (AW),
      .MAP_W          (MW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (wr_valid),
      .wr_data       (wr_data),
      .ready_to_prev (ready_to_prev),
      .mem_we        (mem_we),
      .mem_bank      (mem_bank),
      .mem_map       (mem_map),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .end_from_next (end_from_next),
      .start_to_next (start_to_next),
      .rd_bank_sel   (rd_bank_sel),
      .overflow      (overflow)
   );

   typedef struct packed {
      logic          bank;
      logic [MW-1:0] map;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t  exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_starts = 0;
   int   starts_snap;

   // Reference write-side state: bank being filled, position, full flags.
   logic       m_bank;
   logic [1:0] m_full;
   int         m_addr, m_map;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // One clock; outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      wr_t e;
      wr_t got;
      @(posedge clk);
      #1;
      if (start_to_next === 1'b1) n_starts++;
      got = {mem_bank, mem_map, mem_addr, mem_wdata};
      check("mem_we", mem_we, exp_q.size() > 0);
      if (mem_we === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("write_bank_map_addr_data", got, e);
      end
   endtask

   task automatic drive_pix(input logic [DW-1:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      if (!m_full[m_bank]) begin
         exp_q.push_back(wr_t'({m_bank, MW'(m_map), AW'(m_addr), d}));
         if (m_addr == PIX - 1) begin
            m_addr = 0;
            if (m_map == NMAPS - 1) begin
               m_map          = 0;
               m_full[m_bank] = 1'b1;
               m_bank         = ~m_bank;
            end else begin
               m_map++;
            end
         end else begin
            m_addr++;
         end
      end
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic write_n(input int n);
      for (int i = 0; i < n; i++) drive_pix($urandom);
   endtask

   task automatic model_reset();
      m_bank = 1'b0;
      m_full = 2'b00;
      m_addr = 0;
      m_map  = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      wr_valid      = 1'b0;
      wr_data       = '0;
      end_from_next = 1'b1;
      model_reset();
      tick();
      tick();
      check("reset_outputs", {mem_we, mem_bank, mem_map, mem_addr, start_to_next, rd_bank_sel, overflow}, '0);
      check("reset_wdata", mem_wdata, '0);
      check("reset_ready", ready_to_prev, 1'b1);
      reset = 1'b0;
      tick();

      // T1: single frame into bank 0, consumer idle
      write_n(FRAME);
      check("t1_no_start_at_frame_done", start_to_next, 1'b0);
      check("t1_ready_bank1_free", ready_to_prev, 1'b1);
      tick();
      check("t1_start_pulse", start_to_next, 1'b1);
      check("t1_rd_bank_sel", rd_bank_sel, 1'b0);

      // T4: consumer keeps end_from_next high for 3 cycles after launch
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_start_one_cycle", start_to_next, 1'b0);
      end
      check("t4_start_count", n_starts, 1);
      end_from_next = 1'b0;
      tick();

      // T2: second frame while consumer is busy -> bank 1, then both full
      write_n(FRAME);
      check("t2_ready_low_both_full", ready_to_prev, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      check("t2_no_second_launch", n_starts, 1);

      // T3: back-pressure with both banks full
      for (int i = 0; i < 3; i++) drive_pix($urandom);
      check("t3_overflow", overflow, 1'b1);
      check("t3_ready_still_low", ready_to_prev, 1'b0);
      end_from_next = 1'b1;
      tick();
      m_full[0] = 1'b0;
      check("t3_ready_after_release", ready_to_prev, 1'b1);
      check("t3_no_start_on_release", start_to_next, 1'b0);
      drive_pix($urandom);
      check("t3_launch_bank1", start_to_next, 1'b1);
      check("t3_rd_bank_sel_1", rd_bank_sel, 1'b1);
      end_from_next = 1'b0;
      write_n(FRAME - 1);
      check("t3_frame3_ready_low", ready_to_prev, 1'b0);
      check("t3_start_count", n_starts, 2);

      // Release bank 1, relaunch bank 0
      end_from_next = 1'b1;
      tick();
      m_full[1] = 1'b0;
      check("rel1_ready", ready_to_prev, 1'b1);
      tick();
      check("rel1_launch_bank0", start_to_next, 1'b1);
      check("rel1_rd_bank_sel_0", rd_bank_sel, 1'b0);
      end_from_next = 1'b0;
      tick();

      // T5: frame_done on bank 1 in the same cycle as release of bank 0
      write_n(FRAME - 1);
      end_from_next = 1'b1;
      drive_pix($urandom);
      m_full[0] = 1'b0;
      check("t5_bank_full_10", dut.bank_full_q, 2'b10);
      check("t5_ready_bank0", ready_to_prev, 1'b1);
      check("t5_no_start_same_cycle", start_to_next, 1'b0);
      tick();
      check("t5_launch_bank1", start_to_next, 1'b1);
      check("t5_rd_bank_sel_1", rd_bank_sel, 1'b1);
      end_from_next = 1'b0;
      tick();

      // T6: reset at pixel 57 of map 1
      write_n(PIX + 57);
      check("t6_pre_reset_map", mem_map, 1'b1);
      check("t6_pre_reset_addr", mem_addr, 56);
      reset = 1'b1;
      #1;
      check("t6_reset_outputs", {mem_we, mem_bank, mem_map, mem_addr, start_to_next, rd_bank_sel, overflow}, '0);
      check("t6_reset_wdata", mem_wdata, '0);
      model_reset();
      end_from_next = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      starts_snap = n_starts;
      for (int i = 0; i < 4; i++) tick();
      check("t6_no_spurious_start", n_starts, starts_snap);
      check("t6_ready_after_reset", ready_to_prev, 1'b1);
      drive_pix($urandom);
      drive_pix($urandom);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
